// File: rtl/cbus_arbiter_pkg.sv
// rtl/cbus_arbiter_pkg.sv - shared CBus request/response types and burst-length constants
package cbus_arbiter_pkg;

  typedef logic [3:0] cbus_len_t;

  // len encodes beats-1
  localparam cbus_len_t MLEN1  = 4'd0;
  localparam cbus_len_t MLEN2  = 4'd1;
  localparam cbus_len_t MLEN4  = 4'd3;
  localparam cbus_len_t MLEN8  = 4'd7;
  localparam cbus_len_t MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    cbus_len_t   len;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// rtl/cbus_arbiter_if.sv - upstream/downstream CBus bundle seen by the arbiter
interface cbus_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_arbiter_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );

endinterface

// File: rtl/cbus_arb_select.sv
// rtl/cbus_arb_select.sv - first valid input at or after start, searching cyclically
module cbus_arb_select #(
  parameter int NUM_INPUTS = 2,
  parameter int IW         = 1
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IW-1:0]         start,
  output logic [IW-1:0]         winner,
  output logic                  any
);

  int idx;

  // Walk the search order backwards so the last hit is the highest-priority one.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_INPUTS;
      if (valid[idx]) begin
        winner = IW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - N:1 CBus arbiter, grant held until last beat
// Build option CBUS_ARBITER_RR_EN: round-robin instead of fixed lowest-index priority.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic           clk,
  input  logic           reset,
  cbus_arbiter_if.slave  bus
);

  localparam int IW = idx_width(NUM_INPUTS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]            state;
  logic [IW-1:0]         index;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         winner;
  logic                  any;
  logic                  done;
  logic [NUM_INPUTS-1:0] valid_vec;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_INPUTS; i++) valid_vec[i] = bus.ireqs[i].valid;
  end

  assign done = (state == BUSY) && bus.oresp.ready && bus.oresp.last;

  cbus_arb_select #(
    .NUM_INPUTS (NUM_INPUTS),
    .IW         (IW)
  ) u_select (
    .valid  (valid_vec),
    .start  (ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          index <= winner;
          state <= BUSY;
        end
        BUSY: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CBUS_ARBITER_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (done) begin
      ptr <= (int'(index) == NUM_INPUTS - 1) ? '0 : index + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // Requests are not latched: masters hold them stable until last.
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) bus.iresps[i] = '0;
    if (state == BUSY) begin
      bus.oreq          = bus.ireqs[index];
      bus.iresps[index] = bus.oresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - directed self-checking bench for cbus_arbiter (NUM_INPUTS=2)
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h8000_0040;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_INPUTS(2)) bus ();

  cbus_arbiter #(.NUM_INPUTS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] nz_resp(input cbus_resp_t r);
    return {63'b0, |r};
  endfunction

  function automatic logic [63:0] nz_req(input cbus_req_t r);
    return {63'b0, |r};
  endfunction

  task automatic set_req(input int i, input logic v, input logic wr, input logic [31:0] a, input cbus_len_t l);
    bus.ireqs[i].valid    = v;
    bus.ireqs[i].is_write = wr;
    bus.ireqs[i].addr     = a;
    bus.ireqs[i].len      = l;
    bus.ireqs[i].strobe   = wr ? 8'hff : 8'h00;
    bus.ireqs[i].data     = {32'hcafe_0000, a};
  endtask

  task automatic set_resp(input logic rdy, input logic lst, input logic [63:0] d);
    bus.oresp.ready = rdy;
    bus.oresp.last  = lst;
    bus.oresp.data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
    set_req(0, 1'b1, 1'b0, A0, MLEN1);
    set_req(1, 1'b1, 1'b0, A1, MLEN1);
    set_resp(1'b1, 1'b1, 64'h55);

    // reset holds everything quiet even with live requests and responses
    step(); settle();
    check_eq("rst_oreq",   nz_req(bus.oreq), 64'd0);
    check_eq("rst_resp0",  nz_resp(bus.iresps[0]), 64'd0);
    check_eq("rst_resp1",  nz_resp(bus.iresps[1]), 64'd0);
    set_req(0, 1'b0, 1'b0, 32'd0, MLEN1);
    set_req(1, 1'b0, 1'b0, 32'd0, MLEN1);
    set_resp(1'b0, 1'b0, 64'd0);
    reset = 1'b0;

    // idle: nothing valid for 10 cycles
    for (int c = 0; c < 10; c++) begin
      step(); settle();
      check_eq("idle_oreq", nz_req(bus.oreq), 64'd0);
    end

    // fixed-priority contention, single beat at cycle 3
    step();
    set_req(0, 1'b1, 1'b0, A0, MLEN1);
    set_req(1, 1'b1, 1'b0, A1, MLEN1);
    settle();
    check_eq("c0_oreq_valid", {63'b0, bus.oreq.valid}, 64'd0);
    step(); settle();
    check_eq("c1_addr",  {32'b0, bus.oreq.addr}, {32'b0, A0});
    check_eq("c1_resp1", nz_resp(bus.iresps[1]), 64'd0);
    step(); settle();
    step();
    set_resp(1'b1, 1'b1, 64'h1234);
    settle();
    check_eq("c3_data0", bus.iresps[0].data, 64'h1234);
    check_eq("c3_last0", {63'b0, bus.iresps[0].last}, 64'd1);
    check_eq("c3_resp1", nz_resp(bus.iresps[1]), 64'd0);
    step();
    set_req(0, 1'b0, 1'b0, 32'd0, MLEN1);
    set_resp(1'b0, 1'b0, 64'd0);
    settle();
    check_eq("c4_idle", {63'b0, bus.oreq.valid}, 64'd0);
    step(); settle();
    check_eq("c5_addr",  {32'b0, bus.oreq.addr}, {32'b0, A1});
    check_eq("c5_valid", {63'b0, bus.oreq.valid}, 64'd1);
    set_resp(1'b1, 1'b1, 64'h9);
    step();
    set_req(1, 1'b0, 1'b0, 32'd0, MLEN1);
    set_resp(1'b0, 1'b0, 64'd0);

    // 4-beat burst on master 1, 5-cycle stall before beat 2 while master 0 waits
    set_req(1, 1'b1, 1'b0, A1, MLEN4);
    step(); settle();
    check_eq("b_grant_addr", {32'b0, bus.oreq.addr}, {32'b0, A1});
    check_eq("b_grant_len",  {60'b0, bus.oreq.len}, {60'b0, MLEN4});
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        for (int s = 0; s < 5; s++) begin
          set_resp(1'b0, 1'b0, 64'hdead);
          set_req(0, 1'b1, 1'b1, A0, MLEN1);
          settle();
          check_eq("stall_addr",  {32'b0, bus.oreq.addr}, {32'b0, A1});
          check_eq("stall_resp0", nz_resp(bus.iresps[0]), 64'd0);
          check_eq("stall_rdy1",  {63'b0, bus.iresps[1].ready}, 64'd0);
          step();
        end
      end
      set_resp(1'b1, b == 3, 64'h00d0 + 64'(b));
      settle();
      check_eq("beat_addr",  {32'b0, bus.oreq.addr}, {32'b0, A1});
      check_eq("beat_data1", bus.iresps[1].data, 64'h00d0 + 64'(b));
      check_eq("beat_last1", {63'b0, bus.iresps[1].last}, {63'b0, b == 3});
      check_eq("beat_resp0", nz_resp(bus.iresps[0]), 64'd0);
      step();
    end
    set_resp(1'b0, 1'b0, 64'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, MLEN1);
    settle();
    check_eq("b_after_idle", {63'b0, bus.oreq.valid}, 64'd0);
    step(); settle();
    check_eq("waiter_addr", {32'b0, bus.oreq.addr}, {32'b0, A0});
    check_eq("waiter_wr",   {63'b0, bus.oreq.is_write}, 64'd1);
    set_resp(1'b1, 1'b1, 64'd1);
    step();
    set_req(0, 1'b0, 1'b0, 32'd0, MLEN1);
    set_resp(1'b0, 1'b0, 64'd0);

    // granted master drops valid before last; grant holds until last
    set_req(0, 1'b1, 1'b0, A0, MLEN2);
    step(); settle();
    check_eq("drop_grant", {32'b0, bus.oreq.addr}, {32'b0, A0});
    set_req(0, 1'b0, 1'b0, A0, MLEN2);
    set_req(1, 1'b1, 1'b0, A1, MLEN1);
    set_resp(1'b1, 1'b0, 64'h77);
    settle();
    check_eq("drop_valid", {63'b0, bus.oreq.valid}, 64'd0);
    check_eq("drop_rdy0",  {63'b0, bus.iresps[0].ready}, 64'd1);
    check_eq("drop_rdy1",  {63'b0, bus.iresps[1].ready}, 64'd0);
    step();
    set_resp(1'b1, 1'b1, 64'h78);
    settle();
    check_eq("drop_last0", {63'b0, bus.iresps[0].last}, 64'd1);
    step();
    set_resp(1'b0, 1'b0, 64'd0);
    settle();
    check_eq("drop_idle", {63'b0, bus.oreq.valid}, 64'd0);
    step(); settle();
    check_eq("drop_next", {32'b0, bus.oreq.addr}, {32'b0, A1});
    set_resp(1'b1, 1'b1, 64'd2);
    step();
    set_req(1, 1'b0, 1'b0, 32'd0, MLEN1);
    set_resp(1'b0, 1'b0, 64'd0);

    // reset pulsed during beat 2 of a 4-beat write
    set_req(0, 1'b1, 1'b1, A0, MLEN4);
    step();
    set_resp(1'b1, 1'b0, 64'h1);
    step();
    set_resp(1'b1, 1'b0, 64'h2);
    settle();
    check_eq("rb_pre_valid", {63'b0, bus.oreq.valid}, 64'd1);
    reset = 1'b1;
    #1;
    check_eq("rb_valid", {63'b0, bus.oreq.valid}, 64'd0);
    check_eq("rb_rdy0",  {63'b0, bus.iresps[0].ready}, 64'd0);
    step();
    reset = 1'b0;
    set_resp(1'b0, 1'b0, 64'd0);
    settle();
    check_eq("rb_rel_idle", {63'b0, bus.oreq.valid}, 64'd0);
    step(); settle();
    check_eq("rb_regrant", {32'b0, bus.oreq.addr}, {32'b0, A0});
    check_eq("rb_regrant_v", {63'b0, bus.oreq.valid}, 64'd1);
    set_resp(1'b1, 1'b1, 64'd3);
    step();
    set_req(0, 1'b0, 1'b0, 32'd0, MLEN1);
    set_resp(1'b0, 1'b0, 64'd0);

    // six single-beat transactions with both masters always valid
    reset = 1'b1;
    step();
    set_req(0, 1'b1, 1'b0, A0, MLEN1);
    set_req(1, 1'b1, 1'b0, A1, MLEN1);
    set_resp(1'b1, 1'b1, 64'hab);
    reset = 1'b0;
    settle();
    check_eq("seq_idle0", {63'b0, bus.oreq.valid}, 64'd0);
    for (int t = 0; t < 6; t++) begin
`ifdef CBUS_ARBITER_RR_EN
      exp_addr = (t % 2 == 0) ? A0 : A1;
`else
      exp_addr = A0;
`endif
      step(); settle();
      check_eq("seq_grant", {32'b0, bus.oreq.addr}, {32'b0, exp_addr});
      check_eq("seq_last",  {63'b0, (exp_addr == A0) ? bus.iresps[0].last : bus.iresps[1].last}, 64'd1);
      step(); settle();
      check_eq("seq_gap", {63'b0, bus.oreq.valid}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
